filter_row_packer: RTL

- Upstream feeder for the filter memory.
- Accepts a serial stream of 8-bit filter weights and packs ROW_LEN consecutive weights into one filter row.
- Emits one write packet per row, laid out as {row address, row data}, which is exactly the filter memory write-channel format.
- Sequences row addresses 0..DEPTH-1 per filter, pads short final rows with zeros, and pulses done when a filter has been fully written.

---
 rtl/filter_row_packer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/filter_row_packer.sv
// Packs a serial stream of weights into filter rows and emits {row address, row data}
// write packets for the filter memory, sequencing addresses 0..DEPTH-1 per filter.
module filter_row_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 5,
  parameter int DEPTH      = 5,
  parameter int ADDR_W     = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ADDR_W+DATA_WIDTH*ROW_LEN-1:0] out_packet,
  output logic                                 done,
  output logic [ADDR_W-1:0]                    row_idx
);

  localparam int RD_W  = DATA_WIDTH * ROW_LEN;
  localparam int CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_col;
  logic [RD_W-1:0]          r_row_buf;
  logic                     r_last_seen;
  logic [ADDR_W-1:0]        r_row_idx;
  logic [ADDR_W+RD_W-1:0]   r_pkt;

  logic                     w_in_xfer;
  logic                     w_out_xfer;
  logic                     w_close;
  logic                     w_filter_end;
  logic [RD_W-1:0]          w_row_ins;

  assign w_in_xfer    = in_valid && in_ready;
  assign w_out_xfer   = (r_state == S_SEND) && out_ready;
  assign w_close      = w_in_xfer && ((r_col == CNT_W'(ROW_LEN - 1)) || in_last);
  assign w_filter_end = (r_row_idx == ADDR_W'(DEPTH - 1)) || r_last_seen;

  // Row buffer with the incoming weight dropped into its lane; on a short final
  // row every lane above the current column is forced to zero.
  always_comb begin
    w_row_ins = r_row_buf;
    for (int l = 0; l < ROW_LEN; l++) begin
      if (CNT_W'(l) == r_col) begin
        w_row_ins[l*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end else if (in_last && (CNT_W'(l) > r_col)) begin
        w_row_ins[l*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_close) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_out_xfer) begin
          w_state_nxt = w_filter_end ? S_DONE : S_FILL;
        end
      end
      S_DONE:  w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // in_ready is also gated by rst so nothing is accepted while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_FILL:  in_ready  = !rst;
      S_SEND:  out_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row_buf   <= '0;
      r_last_seen <= 1'b0;
      r_row_idx   <= '0;
      r_pkt       <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_close) begin
            r_pkt       <= {r_row_idx, w_row_ins};
            r_last_seen <= in_last;
            r_col       <= '0;
            r_row_buf   <= '0;
          end else if (w_in_xfer) begin
            r_row_buf <= w_row_ins;
            r_col     <= r_col + CNT_W'(1);
          end
        end
        S_SEND: begin
          if (w_out_xfer && !w_filter_end) begin
            r_row_idx <= r_row_idx + ADDR_W'(1);
          end
        end
        S_DONE: begin
          r_row_idx   <= '0;
          r_last_seen <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_packet = r_pkt;
  assign row_idx    = r_row_idx;

endmodule
